// File: rtl/mem_pkg.sv
// Shared definitions for the data-cache slice: word/address widths, FSM encoding
// and the tag-width helper used to size the tag store.
package mem_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } cache_state_t;

  // Address bits left over once byte, word-in-line and line-index bits are removed.
  function automatic int tag_width(input int num_lines, input int words_per_line);
    return ADDR_W - BYTE_OFF_W - $clog2(words_per_line) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational read port,
// a single-word store port and a line-fill port that validates the line on its last word.
module dcache_line_array
  import mem_pkg::*;
#(
  parameter  int NUM_LINES      = 8,
  parameter  int WORDS_PER_LINE = 4,
  parameter  int TAG_W          = tag_width(NUM_LINES, WORDS_PER_LINE),
  localparam int INDEX_W        = $clog2(NUM_LINES),
  localparam int OFF_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [OFF_W-1:0]   rd_offset,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [WORD_W-1:0]  rd_data,
  input  logic               word_we,
  input  logic [INDEX_W-1:0] word_index,
  input  logic [OFF_W-1:0]   word_offset,
  input  logic [WORD_W-1:0]  word_data,
  input  logic               fill_we,
  input  logic               fill_last,
  input  logic [INDEX_W-1:0] fill_index,
  input  logic [OFF_W-1:0]   fill_offset,
  input  logic [WORD_W-1:0]  fill_data,
  input  logic [TAG_W-1:0]   fill_tag
);

  logic [NUM_LINES-1:0] valid_bits;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [WORD_W-1:0]    data_mem [NUM_LINES][WORDS_PER_LINE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_bits <= '0;
    end else if (fill_we && fill_last) begin
      valid_bits[fill_index] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[fill_index][fill_offset] <= fill_data;
      if (fill_last) begin
        tag_mem[fill_index] <= fill_tag;
      end
    end else if (word_we) begin
      data_mem[word_index][word_offset] <= word_data;
    end
  end

  assign rd_valid = valid_bits[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index][rd_offset];

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache with same-cycle read hits,
// word-per-cycle line refill on a read miss, and saturating hit/miss counters.
module dcache_direct_mapped
  import mem_pkg::*;
#(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [ADDR_W-1:0] Address,
  input  logic [WORD_W-1:0] Write_Data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [WORD_W-1:0] Read_data,
  output logic              Stall,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [WORD_W-1:0] Mem_Write_Data,
  output logic              Mem_MemRead,
  output logic              Mem_MemWrite,
  input  logic [WORD_W-1:0] Mem_Read_data,
  output logic [CNT_W-1:0]  Hit_Count,
  output logic [CNT_W-1:0]  Miss_Count
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int TAG_W   = tag_width(NUM_LINES, WORDS_PER_LINE);

  logic [TAG_W-1:0]   addr_tag;
  logic [INDEX_W-1:0] addr_index;
  logic [OFF_W-1:0]   addr_offset;
  logic               unused_byte_bits;

  cache_state_t       state;
  logic [OFF_W-1:0]   cnt;

  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [WORD_W-1:0]  line_data;

  logic               hit;
  logic               idle_active;
  logic               read_req;
  logic               read_hit;
  logic               read_miss;
  logic               write_req;
  logic               refilling;
  logic               refill_last;

  assign addr_tag         = Address[ADDR_W-1 -: TAG_W];
  assign addr_index       = Address[BYTE_OFF_W+OFF_W +: INDEX_W];
  assign addr_offset      = Address[BYTE_OFF_W +: OFF_W];
  assign unused_byte_bits = ^Address[BYTE_OFF_W-1:0];

  assign hit         = line_valid && (line_tag == addr_tag);
  assign idle_active = RESET_N && (state == IDLE);
  // A simultaneous load and store is handled purely as a store.
  assign read_req    = MemRead && !MemWrite;
  assign read_hit    = idle_active && read_req && hit;
  assign read_miss   = idle_active && read_req && !hit;
  assign write_req   = idle_active && MemWrite;
  assign refilling   = RESET_N && (state == REFILL);
  assign refill_last = (cnt == OFF_W'(WORDS_PER_LINE - 1));

  dcache_line_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W)
  ) u_lines (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .rd_index    (addr_index),
    .rd_offset   (addr_offset),
    .rd_valid    (line_valid),
    .rd_tag      (line_tag),
    .rd_data     (line_data),
    .word_we     (write_req && hit),
    .word_index  (addr_index),
    .word_offset (addr_offset),
    .word_data   (Write_Data),
    .fill_we     (refilling),
    .fill_last   (refill_last),
    .fill_index  (addr_index),
    .fill_offset (cnt),
    .fill_data   (Mem_Read_data),
    .fill_tag    (addr_tag)
  );

  // CPU and memory-side outputs; everything is gated by reset so the pipeline
  // sees no stall and the memory sees no request while RESET_N is low.
  always_comb begin
    Read_data      = '0;
    Stall          = 1'b0;
    Mem_Address    = '0;
    Mem_Write_Data = '0;
    Mem_MemRead    = 1'b0;
    Mem_MemWrite   = 1'b0;
    if (write_req) begin
      Mem_MemWrite   = 1'b1;
      Mem_Address    = Address;
      Mem_Write_Data = Write_Data;
    end else if (read_hit) begin
      Read_data = line_data;
    end else if (read_miss) begin
      Stall = 1'b1;
    end else if (refilling) begin
      Stall       = 1'b1;
      Mem_MemRead = 1'b1;
      Mem_Address = {addr_tag, addr_index, cnt, {BYTE_OFF_W{1'b0}}};
    end
  end

  // Refill sequencing and saturating performance counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      cnt        <= '0;
      Hit_Count  <= '0;
      Miss_Count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_miss) begin
            state <= REFILL;
            cnt   <= '0;
          end
        end
        REFILL: begin
          cnt <= cnt + 1'b1;
          if (refill_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (read_hit && (Hit_Count != '1)) begin
        Hit_Count <= Hit_Count + 1'b1;
      end
      if (read_miss && (Miss_Count != '1)) begin
        Miss_Count <= Miss_Count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed bench for dcache_direct_mapped: stimulus queues expected transactions and refill
// addresses, a negedge monitor pops and compares them whenever the DUT completes one.
module tb_dcache_direct_mapped;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        mem_read;
  } txn_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Write_Data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        Stall;
  logic [31:0] Mem_Address;
  logic [31:0] Mem_Write_Data;
  logic        Mem_MemRead;
  logic        Mem_MemWrite;
  logic [31:0] Mem_Read_data;
  logic [15:0] Hit_Count;
  logic [15:0] Miss_Count;

  logic [31:0] data_mem [0:255];
  txn_t        exp_q[$];
  logic [31:0] fill_q[$];
  txn_t        mon_txn;
  logic [31:0] mon_fill;
  int          check_count = 0;
  int          passed_count = 0;

  dcache_direct_mapped dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .Address        (Address),
    .Write_Data     (Write_Data),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .Read_data      (Read_data),
    .Stall          (Stall),
    .Mem_Address    (Mem_Address),
    .Mem_Write_Data (Mem_Write_Data),
    .Mem_MemRead    (Mem_MemRead),
    .Mem_MemWrite   (Mem_MemWrite),
    .Mem_Read_data  (Mem_Read_data),
    .Hit_Count      (Hit_Count),
    .Miss_Count     (Miss_Count)
  );

  always #5 CLK = ~CLK;

  // Data memory: combinational read, posedge write.
  assign Mem_Read_data = data_mem[Mem_Address[9:2]];
  always @(posedge CLK) begin
    if (Mem_MemWrite) data_mem[Mem_Address[9:2]] <= Mem_Write_Data;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t", name, actual, actual, expected, expected, $time);
    else
      passed_count++;
  endtask

  task automatic report_fail(input string name);
    check_count++;
    $display("[TB] FAIL %s: unexpected DUT activity at %0t (addr 0x%h)", name, $time, Mem_Address);
  endtask

  // Monitor: compares every refill beat and every completed (non-stalled) CPU access.
  always @(negedge CLK) begin
    if (RESET_N && Mem_MemRead) begin
      if (fill_q.size() == 0) report_fail("refill beat");
      else begin
        mon_fill = fill_q.pop_front();
        check_output("refill address", Mem_Address, mon_fill);
      end
    end
    if (RESET_N && (MemRead || MemWrite) && !Stall) begin
      if (exp_q.size() == 0) report_fail("completed access");
      else begin
        mon_txn = exp_q.pop_front();
        check_output("read data", Read_data, mon_txn.rdata);
        check_output("mem address", Mem_Address, mon_txn.addr);
        check_output("mem write data", Mem_Write_Data, mon_txn.wdata);
        check_output("mem write enable", {31'b0, Mem_MemWrite}, {31'b0, mon_txn.mem_write});
        check_output("mem read enable", {31'b0, Mem_MemRead}, {31'b0, mon_txn.mem_read});
      end
    end
  end

  task automatic wait_accept(input int exp_stall);
    int  stalls = 0;
    bit  done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge CLK);
      if (!Stall) done = 1'b1;
      else stalls++;
    end
    check_output("stall cycles", stalls, exp_stall);
  endtask

  task automatic push_fills(input logic [31:0] addr, input int beats);
    logic [31:0] base;
    base = addr & 32'hFFFF_FFF0;
    for (int i = 0; i < beats; i++) fill_q.push_back(base + 32'(i * 4));
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data, input int exp_stall);
    txn_t t;
    t = '{rdata: exp_data, addr: 32'h0, wdata: 32'h0, mem_write: 1'b0, mem_read: 1'b0};
    exp_q.push_back(t);
    if (exp_stall > 0) push_fills(addr, 4);
    Address = addr;
    MemRead = 1'b1;
    wait_accept(exp_stall);
    @(posedge CLK);
    #1 MemRead = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t = '{rdata: 32'h0, addr: addr, wdata: data, mem_write: 1'b1, mem_read: 1'b0};
    exp_q.push_back(t);
    Address    = addr;
    Write_Data = data;
    MemWrite   = 1'b1;
    wait_accept(0);
    @(posedge CLK);
    #1 MemWrite = 1'b0;
    Write_Data = '0;
    check_output("memory after write", data_mem[addr[9:2]], data);
  endtask

  task automatic check_counters(input int hits, input int misses);
    check_output("hit count", {16'b0, Hit_Count}, 32'(hits));
    check_output("miss count", {16'b0, Miss_Count}, 32'(misses));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) data_mem[i] = '0;
    data_mem[0]  = 32'd43;
    data_mem[1]  = 32'd21;
    data_mem[2]  = 32'd34;
    data_mem[3]  = 32'd54;
    data_mem[16] = 32'd52;
    data_mem[32] = 32'd0;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    txn_t t;
    // Reset with a read request pending: everything must stay quiet.
    Address = 32'h40;
    MemRead = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_output("stall in reset", {31'b0, Stall}, 32'd0);
    check_output("read data in reset", Read_data, 32'd0);
    check_output("mem read in reset", {31'b0, Mem_MemRead}, 32'd0);
    check_counters(0, 0);
    MemRead = 1'b0;
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;

    // Cold miss, then hit in the same line.
    do_read(32'h0, 32'd43, 5);
    check_counters(1, 1);
    do_read(32'h4, 32'd21, 0);
    check_counters(2, 1);

    // Write hit updates cache and memory.
    do_write(32'h8, 32'd99);
    do_read(32'h8, 32'd99, 0);
    check_counters(3, 1);

    // Write miss: memory only, no allocation.
    do_write(32'h40, 32'd7);
    do_read(32'h40, 32'd7, 5);
    check_counters(4, 2);

    // Conflict on index 0.
    do_read(32'h80, 32'd0, 5);
    check_counters(5, 3);
    do_read(32'h0, 32'd43, 5);
    check_counters(6, 4);
    do_read(32'h8, 32'd99, 0);
    check_counters(7, 4);

    // Reset asserted during the second refill cycle of a miss on 0x80.
    fill_q.push_back(32'h80);
    Address = 32'h80;
    MemRead = 1'b1;
    @(negedge CLK);
    check_output("stall on detect", {31'b0, Stall}, 32'd1);
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET_N = 1'b0;
    #1;
    check_output("stall after reset", {31'b0, Stall}, 32'd0);
    check_output("mem read after reset", {31'b0, Mem_MemRead}, 32'd0);
    check_output("mem address after reset", Mem_Address, 32'd0);
    check_counters(0, 0);
    t = '{rdata: 32'd0, addr: 32'h0, wdata: 32'h0, mem_write: 1'b0, mem_read: 1'b0};
    exp_q.push_back(t);
    push_fills(32'h80, 4);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    wait_accept(5);
    @(posedge CLK);
    #1 MemRead = 1'b0;
    check_counters(1, 1);

    repeat (2) @(posedge CLK);
    check_output("pending accesses", exp_q.size(), 32'd0);
    check_output("pending refill beats", fill_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed_count, check_count);
    $finish;
  end

endmodule
